// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller: latched nibbles, blank/blink masks, leading-zero suppression.
// Optional time-multiplexed scan bus is compiled in when SEG7_SCAN_EN is defined.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   blank_mask_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  input  logic                    lz_en_i,
  output logic [7*NUM_DIGITS-1:0] hex_o,
  output logic [6:0]              scan_seg_o,
  output logic [NUM_DIGITS-1:0]   scan_an_o,
  output logic                    blink_phase_o
);

  localparam int BlinkW = $clog2(BLINK_DIV);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLINK_DIV < 2 || SCAN_DIV < 2) begin : gParamCheck
    $error("seg7_display_ctrl: illegal parameter value");
  end

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    lz_q;
  logic                    valid_q;
  logic [BlinkW-1:0]       blinkCnt_q;
  logic [BlinkW-1:0]       blinkCnt_d;
  logic                    blinkPhase_q;
  logic                    blinkPhase_d;
  logic                    blinkWrap;
  logic [7*NUM_DIGITS-1:0] hexSeg;

  function automatic logic [6:0] decodeNibble(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h58;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h18;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_comb begin
    blinkWrap    = (blinkCnt_q == BlinkW'(BLINK_DIV - 1));
    blinkCnt_d   = blinkWrap ? '0 : blinkCnt_q + 1'b1;
    blinkPhase_d = blinkPhase_q ^ blinkWrap;
  end

  // The blink counter free-runs; load_i never disturbs it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_q      <= '0;
      blank_q      <= '0;
      blink_q      <= '0;
      lz_q         <= 1'b0;
      valid_q      <= 1'b0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      if (load_i) begin
        value_q <= value_i;
        blank_q <= blank_mask_i;
        blink_q <= blink_mask_i;
        lz_q    <= lz_en_i;
        valid_q <= 1'b1;
      end
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  // Walk from the top digit down so upperZero covers nibbles k..NUM_DIGITS-1;
  // it looks only at nibble values, never at the blank mask.
  always_comb begin
    logic upperZero;
    logic digitBlank;
    upperZero  = 1'b1;
    digitBlank = 1'b0;
    hexSeg     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upperZero  = upperZero && (value_q[4*k +: 4] == 4'h0);
      digitBlank = !valid_q || blank_q[k] || (blink_q[k] && blinkPhase_q) ||
                   (lz_q && (k > 0) && upperZero);
      hexSeg[7*k +: 7] = digitBlank ? 7'h7F : decodeNibble(value_q[4*k +: 4]);
    end
  end

  assign hex_o         = hexSeg;
  assign blink_phase_o = blinkPhase_q;

`ifdef SEG7_SCAN_EN
  localparam int ScanW = $clog2(SCAN_DIV);
  localparam int IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [ScanW-1:0] scanCnt_q;
  logic [IdxW-1:0]  scanIdx_q;
  logic             scanWrap;

  assign scanWrap = (scanCnt_q == ScanW'(SCAN_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scanCnt_q <= '0;
      scanIdx_q <= '0;
    end else begin
      scanCnt_q <= scanWrap ? '0 : scanCnt_q + 1'b1;
      if (scanWrap) begin
        scanIdx_q <= (scanIdx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : scanIdx_q + 1'b1;
      end
    end
  end

  always_comb begin
    scan_seg_o = 7'h7F;
    scan_an_o  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scanIdx_q == IdxW'(k)) begin
        scan_seg_o   = hexSeg[7*k +: 7];
        scan_an_o[k] = 1'b0;
      end
    end
  end
`else
  assign scan_seg_o = 7'h7F;
  assign scan_an_o  = '1;
`endif

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl: directed scenarios followed by randomized
// traffic, all compared against a cycle-count based reference model.
module tb_seg7_display_ctrl;

  localparam int ND = 8;
  localparam int BD = 4;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          load = 1'b0;
  logic [31:0]   value = '0;
  logic [7:0]    blankMask = '0;
  logic [7:0]    blinkMask = '0;
  logic          lzEn = 1'b0;
  logic [55:0]   hexOut;
  logic [6:0]    scanSeg;
  logic [7:0]    scanAn;
  logic          blinkPhase;

  logic [31:0]   mValue = '0;
  logic [7:0]    mBlank = '0;
  logic [7:0]    mBlink = '0;
  logic          mLz = 1'b0;
  logic          mValid = 1'b0;
  int            cycles = 0;

  int            passCount = 0;
  int            totalCount = 0;

  logic [6:0]    segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                                   7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_display_ctrl #(
    .NUM_DIGITS(ND),
    .BLINK_DIV (BD),
    .SCAN_DIV  (SD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .load_i       (load),
    .value_i      (value),
    .blank_mask_i (blankMask),
    .blink_mask_i (blinkMask),
    .lz_en_i      (lzEn),
    .hex_o        (hexOut),
    .scan_seg_o   (scanSeg),
    .scan_an_o    (scanAn),
    .blink_phase_o(blinkPhase)
  );

  // Reference: blink phase and scan index follow directly from cycles since reset.
  function automatic logic modelPhase();
    return ((cycles / BD) % 2) == 1;
  endfunction

  function automatic logic [55:0] modelHex();
    logic [55:0] h;
    logic        blank;
    int          nib;
    h = '0;
    for (int k = 0; k < ND; k++) begin
      nib   = int'((mValue >> (4 * k)) & 32'hF);
      blank = !mValid || mBlank[k] || (mBlink[k] && modelPhase()) ||
              (mLz && k > 0 && (mValue >> (4 * k)) == 32'd0);
      h[7*k +: 7] = blank ? 7'h7F : segTable[nib];
    end
    return h;
  endfunction

  task automatic compare(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCount++;
    assert (got === exp) passCount += 1;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic checkOutput(input string tag);
    logic [55:0] expHex;
    logic [7:0]  expAn;
    logic [6:0]  expSeg;
    int          idx;
    expHex = modelHex();
`ifdef SEG7_SCAN_EN
    idx    = (cycles / SD) % ND;
    expAn  = ~(8'd1 << idx);
    expSeg = expHex[7*idx +: 7];
`else
    idx    = 0;
    expAn  = 8'hFF;
    expSeg = 7'h7F;
`endif
    compare({tag, "/hex"}, 64'(hexOut), 64'(expHex));
    compare({tag, "/phase"}, 64'(blinkPhase), 64'(modelPhase()));
    compare({tag, "/an"}, 64'(scanAn), 64'(expAn));
    compare({tag, "/seg"}, 64'(scanSeg), 64'(expSeg));
  endtask

  task automatic applyStimulus(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rstN) begin
        mValue = '0; mBlank = '0; mBlink = '0; mLz = 1'b0; mValid = 1'b0;
        cycles = 0;
      end else begin
        if (load) begin
          mValue = value; mBlank = blankMask; mBlink = blinkMask; mLz = lzEn; mValid = 1'b1;
        end
        cycles++;
      end
      #1;
      checkOutput(tag);
    end
  endtask

  initial begin
    $display("[TB] seg7_display_ctrl bench start");

    rstN = 1'b0;
    applyStimulus(2, "reset");
    compare("reset_hex_const", 64'(hexOut), {8'h0, {8{7'h7F}}});
    rstN = 1'b1;
    applyStimulus(3, "idle_pre");
    compare("phase_before_edge4", 64'(blinkPhase), 64'd0);
    applyStimulus(2, "idle_post");
    compare("phase_after_edge4", 64'(blinkPhase), 64'd1);

    value = 32'h0123ABCD; blankMask = '0; blinkMask = '0; lzEn = 1'b0; load = 1'b1;
    applyStimulus(1, "load_hex");
    load = 1'b0;
    compare("load_hex_const", 64'(hexOut),
            64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}));
    applyStimulus(2, "hold_hex");

    value = 32'h00000050; lzEn = 1'b1; load = 1'b1;
    applyStimulus(1, "lz_50");
    load = 1'b0;
    compare("lz_50_const", 64'(hexOut), 64'({{6{7'h7F}}, 7'h12, 7'h40}));

    value = 32'h0; load = 1'b1;
    applyStimulus(1, "lz_zero");
    load = 1'b0;
    compare("lz_zero_const", 64'(hexOut), 64'({{7{7'h7F}}, 7'h40}));

    value = 32'h11111111; lzEn = 1'b0; blinkMask = 8'h01; load = 1'b1;
    applyStimulus(1, "blink_load");
    load = 1'b0;
    applyStimulus(12, "blink_run");
    blankMask = 8'h80; load = 1'b1;
    applyStimulus(1, "blank_load");
    load = 1'b0;
    compare("blank_digit7", 64'(hexOut[55:49]), 64'h7F);
    applyStimulus(10, "blank_run");

    value = 32'h76543210; blankMask = '0; blinkMask = '0; load = 1'b1;
    applyStimulus(1, "scan_load");
    load = 1'b0;
    applyStimulus(21, "scan_run");
    rstN = 1'b0;
    applyStimulus(1, "mid_reset");
    compare("mid_reset_hex", 64'(hexOut), {8'h0, {8{7'h7F}}});
`ifdef SEG7_SCAN_EN
    compare("mid_reset_an", 64'(scanAn), 64'hFE);
`else
    compare("mid_reset_an", 64'(scanAn), 64'hFF);
`endif
    rstN = 1'b1;
    applyStimulus(3, "post_reset");

    for (int i = 0; i < 300; i++) begin
      rstN      = ($urandom_range(39) != 0);
      load      = ($urandom_range(3) == 0);
      value     = ($urandom_range(1) == 0) ? $urandom() : ($urandom() & 32'h000000FF);
      blankMask = 8'($urandom()) & 8'($urandom());
      blinkMask = 8'($urandom());
      lzEn      = 1'($urandom());
      applyStimulus(1, "random");
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
